// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory port arbiter and the CPU top level.
package cpu_mem_pkg;

    // Default widths, also used by the CPU top level.
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StResp
    } arb_state_e;

    // Port-select encoding for the granted requester.
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating 4-bit starvation counter with clear, increment and threshold compare.
module arb_starve_ctr #(
    parameter int unsigned THRESH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] cnt,
    output logic       hit
);

    logic [3:0] cnt_q, cnt_d;

    // Next count: clear wins over increment; increment saturates at 15.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign hit = (cnt_q >= 4'(THRESH));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the load/store port.
// Data wins contested grants unless the fetch port has been passed over STARVE_MAX times.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = cpu_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W     = cpu_mem_pkg::DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    import cpu_mem_pkg::*;

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic       grant;
    logic       grant_sel;
    logic       ctr_clr;
    logic       ctr_inc;
    logic       starve_hit;
    logic [3:0] starve_cnt;

    arb_starve_ctr #(
        .THRESH (STARVE_MAX)
    ) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .inc (ctr_inc),
        .cnt (starve_cnt),
        .hit (starve_hit)
    );

    // Next-state, grant decision and registered-output next values.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant       = 1'b0;
        grant_sel   = SEL_D;
        ctr_clr     = 1'b0;
        ctr_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (d_req && !(i_req && starve_hit)) begin
                    grant     = 1'b1;
                    grant_sel = SEL_D;
                end else if (i_req) begin
                    grant     = 1'b1;
                    grant_sel = SEL_I;
                end
            end
            StBusyI: begin
                if (mem_ready) begin
                    i_rdata_d   = mem_rdata;
                    i_ack_d     = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'h0;
                    state_d     = StResp;
                end
            end
            StBusyD: begin
                if (mem_ready) begin
                    d_rdata_d   = mem_rdata;
                    d_ack_d     = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'h0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                // Ack is visible this cycle; requester drops req before next IDLE.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Latch the granted port's request so later input changes do not matter.
        if (grant) begin
            mem_req_d = 1'b1;
            if (grant_sel == SEL_D) begin
                state_d     = StBusyD;
                mem_we_d    = d_we;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
                mem_wstrb_d = d_we ? d_wstrb : 4'h0;
                ctr_inc     = i_req;
            end else begin
                state_d     = StBusyI;
                mem_we_d    = 1'b0;
                mem_addr_d  = i_addr;
                mem_wstrb_d = 4'h0;
                ctr_clr     = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'h0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays both requesters and the memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [9:0]  i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (10),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
        chk({tag, "_i_ack"}, 32'(i_ack), 32'h0);
        chk({tag, "_d_ack"}, 32'(d_ack), 32'h0);
        chk({tag, "_i_rdata"}, i_rdata, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_starve_cnt"}, 32'(dut.starve_cnt), 32'h0);
    endtask

    initial begin
        logic [31:0] i_exp;
        int          n_d;
        bit          done;

        rst = 1'b1;   i_req = 1'b0;  i_addr = '0;  d_req = 1'b0;  d_we = 1'b0;
        d_addr = '0;  d_wdata = '0;  d_wstrb = '0; mem_ready = 1'b0; mem_rdata = '0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Single fetch with zero wait states.
        i_req = 1'b1; i_addr = 10'h004;
        step();
        chk("fetch_mem_req", 32'(mem_req), 32'h1);
        chk("fetch_mem_addr", 32'(mem_addr), 32'h004);
        chk("fetch_mem_we", 32'(mem_we), 32'h0);
        chk("fetch_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("fetch_no_early_ack", 32'(i_ack), 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        chk("fetch_i_ack", 32'(i_ack), 32'h1);
        chk("fetch_i_rdata", i_rdata, 32'h0050_0093);
        chk("fetch_mem_req_drop", 32'(mem_req), 32'h0);
        i_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("fetch_ack_one_cycle", 32'(i_ack), 32'h0);

        // Spurious ready while idle with no requests.
        mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        chk("spur_mem_req", 32'(mem_req), 32'h0);
        chk("spur_i_ack", 32'(i_ack), 32'h0);
        chk("spur_d_ack", 32'(d_ack), 32'h0);
        step();
        chk("spur_i_rdata_hold", i_rdata, 32'h0050_0093);
        chk("spur_mem_req2", 32'(mem_req), 32'h0);
        mem_ready = 1'b0;

        // Contention: store wins, fetch granted in the next IDLE.
        i_req = 1'b1; i_addr = 10'h008;
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        step();
        chk("cont_mem_req", 32'(mem_req), 32'h1);
        chk("cont_mem_we", 32'(mem_we), 32'h1);
        chk("cont_mem_addr", 32'(mem_addr), 32'h010);
        chk("cont_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("cont_mem_wstrb", 32'(mem_wstrb), 32'hF);
        mem_ready = 1'b1; mem_rdata = 32'h0;
        step();
        chk("cont_d_ack", 32'(d_ack), 32'h1);
        chk("cont_i_ack_not_yet", 32'(i_ack), 32'h0);
        chk("cont_starve_cnt", 32'(dut.starve_cnt), 32'h1);
        d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("cont_idle_mem_req", 32'(mem_req), 32'h0);
        step();
        chk("cont_fetch_mem_req", 32'(mem_req), 32'h1);
        chk("cont_fetch_addr", 32'(mem_addr), 32'h008);
        chk("cont_fetch_we", 32'(mem_we), 32'h0);
        chk("cont_fetch_wstrb", 32'(mem_wstrb), 32'h0);
        chk("cont_fetch_clr_cnt", 32'(dut.starve_cnt), 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        chk("cont_fetch_ack", 32'(i_ack), 32'h1);
        chk("cont_fetch_rdata", i_rdata, 32'h1111_1111);
        i_req = 1'b0; mem_ready = 1'b0;
        step();

        // Starvation: both ports always requesting; expect 4 data grants then a fetch.
        i_req = 1'b1; i_addr = 10'h00C;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h030; d_wstrb = 4'h0;
        n_d = 0; done = 1'b0; i_exp = '0;
        for (int c = 0; c < 80 && !done; c++) begin
            mem_ready = mem_req;
            mem_rdata = 32'hF000_0000 | 32'(c);
            if (mem_req && (mem_addr == 10'h00C)) begin
                chk("starve_cnt_cleared", 32'(dut.starve_cnt), 32'h0);
                i_exp = mem_rdata;
            end
            step();
            if (d_ack) n_d++;
            if (i_ack) begin
                done = 1'b1;
                chk("starve_i_rdata", i_rdata, i_exp);
            end
        end
        chk("starve_fetch_done", 32'(done), 32'h1);
        chk("starve_d_grants", 32'(n_d), 32'd4);
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("starve_cnt_after", 32'(dut.starve_cnt), 32'h0);

        // Wait states: load from 0x020, ready in the fourth BUSY cycle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'hF;
        step();
        for (int k = 1; k <= 4; k++) begin
            chk("wait_mem_req", 32'(mem_req), 32'h1);
            chk("wait_mem_addr", 32'(mem_addr), 32'h020);
            chk("wait_mem_we", 32'(mem_we), 32'h0);
            chk("wait_mem_wstrb", 32'(mem_wstrb), 32'h0);
            chk("wait_no_ack", 32'(d_ack), 32'h0);
            if (k == 1) d_addr = 10'h3FF;  // post-grant input changes must not matter
            if (k == 4) begin
                mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
            end
            step();
        end
        chk("wait_d_ack", 32'(d_ack), 32'h1);
        chk("wait_d_rdata", d_rdata, 32'h1234_5678);
        chk("wait_i_rdata_hold", i_rdata, i_exp);
        d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("wait_ack_drop", 32'(d_ack), 32'h0);

        // Reset in the middle of a data access.
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h155; d_wdata = 32'h55AA_55AA; d_wstrb = 4'h3;
        step();
        chk("rst_busy_mem_req", 32'(mem_req), 32'h1);
        chk("rst_busy_wstrb", 32'(mem_wstrb), 32'h3);
        rst = 1'b1;
        step();
        chk_reset_vals("rst_mid");
        rst = 1'b0; d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        chk("rst_after_d_ack", 32'(d_ack), 32'h0);
        chk("rst_after_mem_req", 32'(mem_req), 32'h0);
        step();
        chk_reset_vals("rst_late_ready");
        mem_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port instruction/data memory between the RV32I core's fetch port and its load/store port. It sits between the CPU top level and the memory. Each port gets a request/acknowledge handshake. Data accesses have priority, and a starvation counter guarantees fetch progress. Only one memory transaction is in flight at a time, and addresses and write data are latched at grant.

## Interface
Parameters:
- ADDR_W, 10, word-address width (matches the core's instruction/data address width)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is waiting (range 1..15)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held high until i_ack
- i_addr  in  ADDR_W  fetch word address
- i_ack  out  1  one-cycle pulse; fetch complete
- i_rdata  out  DATA_W  fetched word; valid when i_ack=1
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  4  store byte enables
- d_ack  out  1  one-cycle pulse; data access complete
- d_rdata  out  DATA_W  load word; valid when d_ack=1
- mem_req  out  1  memory transaction active
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  4  byte enables; 0 for all reads
- mem_ready  in  1  memory completion; read data on mem_rdata in the same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE transitions:
  - No request: stay in IDLE.
  - Only d_req: go to BUSY_D.
  - Only i_req: go to BUSY_I.
  - Both requests: go to BUSY_D, unless starve_cnt ≥ STARVE_MAX, in which case go to BUSY_I.
- On grant, register mem_addr, mem_we, mem_wdata and mem_wstrb from the granted port.
  - Fetch grants force mem_we=0 and mem_wstrb=0.
  - Data loads force mem_wstrb=0.
- BUSY_x: hold mem_req=1 and all mem_* outputs stable until mem_ready=1.
  - On mem_ready, capture mem_rdata into the granted port's rdata register, set that port's ack register, and go to RESP.
- RESP: the ack is high for exactly this cycle; next state is IDLE unconditionally.
  - This gives the requester one cycle to drop its req, so the same request is never re-granted.
- starve_cnt (4 bits):
  - Clears on every fetch grant.
  - Increments, saturating at 15, on a data grant made while i_req=1.
  - Unchanged on a data grant made while i_req=0.
- rdata registers hold their value between acks. Stores also update d_rdata with mem_rdata, and its contents are don't-care.
- mem_ready is ignored in IDLE and RESP.
- Requesters keep addr/data stable while req is high. The arbiter's behaviour does not depend on changes after grant, because it latched them at grant.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, starve_cnt=0.
- Reset mid-transaction: next cycle is IDLE with mem_req=0. Any mem_ready arriving afterwards is ignored, and no ack is issued.
- Minimum per-access occupancy is 3 cycles, with mem_ready returned in the first BUSY cycle:
  - Cycle 0: IDLE samples req.
  - Cycle 1: BUSY, mem_req=1, mem_ready.
  - Cycle 2: RESP, ack=1.
  - Cycle 3: IDLE.
- With a memory wait of W cycles (mem_ready in BUSY cycle 1+W), the ack arrives W cycles later.
- Back-to-back traffic on both ports alternates naturally only through the starvation rule. Otherwise data wins every contested IDLE.
- All outputs are registered; there are no combinational paths from any input to any output.

## Structure
- Shared package cpu_mem_pkg holds:
  - the state enum (IDLE, BUSY_I, BUSY_D, RESP);
  - port-select constants SEL_I and SEL_D;
  - the default widths ADDR_W and DATA_W, reused by the CPU top level.
- One natural sub-module is arb_starve_ctr: a saturating counter with clr, inc and ≥-threshold compare.
- Everything else lives in mem_port_arbiter.

## Test plan
- Single fetch: i_req=1, i_addr=0x004, mem_ready in the first BUSY cycle, mem_rdata=0x00500093 → mem_req for 1 cycle with mem_addr=0x004, mem_we=0, mem_wstrb=0; i_ack pulses on cycle 2 with i_rdata=0x00500093.
- Contention: i_req and d_req both asserted in the same IDLE cycle, with d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF, d_wstrb=0xF → data is served first (mem_we=1, mem_wstrb=0xF); the fetch is granted in the next IDLE.
- Starvation: i_req held high, d_req reasserted after every d_ack, STARVE_MAX=4 → exactly 4 data grants, then one fetch grant, then starve_cnt reads 0.
- Wait states: mem_ready delayed 3 cycles on a load from 0x020 with rdata 0x12345678 → mem_* outputs stay stable for 4 BUSY cycles; d_ack arrives on cycle 5 with d_rdata=0x12345678.
- Reset mid-BUSY: rst asserted while in BUSY_D, then mem_ready pulsed after reset → no ack, mem_req=0, all outputs at their reset values.
- Spurious ready: mem_ready=1 while in IDLE with no requests → no ack and no state change.
